lut_neuron_loader: RTL
======================

# lut_neuron_loader

Runtime-loadable LUT neuron for the quantized LogicNets layers. A configuration stream writes a complete 2^IN_BITS-entry truth table into distributed RAM, and the block then answers lookups through a valid/ready pipeline with one cycle of latency. It lets a layer's neurons be re-programmed in-system instead of regenerated as fixed-ROM modules. It sits between the layer-config DMA and the neuron's place in the layer datapath.

## Interface
- IN_BITS, 6, lookup address width; table depth DEPTH = 2^IN_BITS
- OUT_BITS, 1, width of each table entry
- CFG_W, 8, config beat width; CFG_W must divide DEPTH*OUT_BITS; BEATS = DEPTH*OUT_BITS/CFG_W (8 at defaults)

- clk  in  1  single clock; everything is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_start  in  1  single-cycle pulse that begins a table load
- cfg_valid  in  1  config beat valid
- cfg_ready  out  1  config beat accepted when cfg_valid && cfg_ready
- cfg_data  in  CFG_W  packed table bits
- loaded  out  1  a complete table has been written since reset
- in_valid  in  1  lookup request valid
- in_ready  out  1  lookup accepted when in_valid && in_ready
- in_data  in  IN_BITS  lookup address
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  OUT_BITS  table[in_data]

## Operation
- States: EMPTY (after reset), LOAD, RUN.
- Reset (async assert on rst_n low) forces:
  - state = EMPTY, beat counter = 0, loaded = 0, cfg_ready = 0, in_ready = 0, out_valid = 0, out_data = 0.
  - All table entries = 0.
- Transitions:
  - EMPTY --cfg_start--> LOAD
  - RUN --cfg_start--> LOAD
  - LOAD --accept of beat BEATS-1--> RUN; loaded set to 1 and stays 1 until reset.
- Packing:
  - The flattened table is DEPTH*OUT_BITS bits. Entry a occupies bits [a*OUT_BITS +: OUT_BITS].
  - Beat k carries flattened bits [k*CFG_W +: CFG_W], LSB first. Beat 0 therefore holds entry 0 at bit 0.
  - Entry address a equals the unsigned value of in_data.
- cfg_ready = 1 only in LOAD. Beats are accepted only in LOAD; cfg_valid in other states is ignored.
- cfg_start in LOAD restarts the load: counter goes to 0 and state stays LOAD. Table contents are not cleared; previously written beats remain until overwritten.
- cfg_start together with a beat accept in LOAD: the beat is written at the current counter, then the counter goes to 0. A restart takes priority over completion, even on beat BEATS-1.
- Lookup acceptance:
  - in_ready = (state == RUN) && (!out_valid || out_ready).
  - Lookups in EMPTY or LOAD are never accepted.
- Output register:
  - On accept, out_data <= table[in_data] and out_valid <= 1.
  - When out_valid && out_ready with no new accept, out_valid <= 0. out_data holds its last value.
- A result already in the output register when a reload starts is kept intact and held until out_ready. Later table writes do not change it.

## Timing
- cfg_start sampled at edge t: state = LOAD and cfg_ready = 1 from t+1.
- Load time: BEATS accepted beats. Final accept at edge t gives state RUN, loaded = 1 and cfg_ready = 0 at t+1. in_ready can be 1 at t+1.
- Lookup latency is 1 cycle: accept at edge t gives out_valid and out_data at t+1.
- Full throughput is 1 lookup/cycle while out_ready = 1, with no bubbles.
- Back-to-back accept and drain in the same cycle: the output register updates with the new result and out_valid stays 1.
- out_valid/out_data are stable while out_valid && !out_ready.
- Reset mid-load or mid-lookup:
  - All outputs return to their reset values immediately (asynchronous).
  - The table is zeroed and loaded = 0.
  - A new cfg_start is required before any lookup.

## Test plan
- Reset, then in_valid = 1 with no load -> in_ready = 0 and out_valid = 0 for 20 cycles; loaded = 0.
- cfg_start, then 8 beats of 8'hA5 at defaults, then sweep in_data 0..63 with out_ready = 1 -> loaded rises the cycle after beat 7; out_data follows bit (a mod 8) of 8'hA5 (a=0 -> 1, a=1 -> 0, a=2 -> 1, a=6 -> 0, a=7 -> 1); 64 results in 64 consecutive cycles.
- Load the table with only entry 37 = 1 (beat 4 = 8'h20, others 0); hold out_ready = 0 after a lookup of 37 -> out_valid = 1 and out_data = 1 held, in_ready = 0. Release out_ready -> one transfer, in_ready returns.
- In RUN, a pending result for address 5, then cfg_start and a reload of all zeros -> the pending out_data is unchanged until drained; no lookup is accepted during LOAD; a lookup of 5 after reload returns 0.
- cfg_start in the same cycle as beat 7 is accepted -> state stays LOAD and the counter is 0; 8 further beats are required before in_ready = 1.
- Assert rst_n = 0 after 3 of 8 beats -> cfg_ready, loaded, in_ready and out_valid drop to 0 asynchronously. After cfg_start and a full reload with 8'hFF, every address returns 1.

Source files
------------

// File: rtl/lut_neuron_loader.sv
// lut_neuron_loader: runtime-loadable LUT neuron; a config stream fills the truth table, then lookups answer with one cycle of latency.
module lut_neuron_loader #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 1,
    parameter int CFG_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CFG_W-1:0]    cfg_data,
    output logic                loaded,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_data
);
    localparam int DEPTH = 1 << IN_BITS;
    localparam int TBITS = DEPTH * OUT_BITS;
    localparam int BEATS = TBITS / CFG_W;
    localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [1:0] EMPTY = 2'd0, LOAD = 2'd1, RUN = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                loaded_q, loaded_d;
    logic [TBITS-1:0]    tbl_q, tbl_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_BITS-1:0] out_data_q, out_data_d;
    logic                cfg_acc, in_acc, last;
    logic [OUT_BITS-1:0] ent [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign ent[i] = tbl_q[i*OUT_BITS +: OUT_BITS];
    end

    assign cfg_ready = state_q == LOAD;
    assign in_ready  = state_q == RUN && (!out_valid_q || out_ready);
    assign cfg_acc   = cfg_valid && cfg_ready;
    assign in_acc    = in_valid && in_ready;
    assign last      = cnt_q == CW'(BEATS - 1);
    assign loaded    = loaded_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // A restart wins over completion, but the beat presented with it is still written.
    always_comb begin
        tbl_d = tbl_q;
        for (int k = 0; k < BEATS; k++)
            if (cfg_acc && cnt_q == CW'(k)) tbl_d[k*CFG_W +: CFG_W] = cfg_data;
        state_d     = cfg_start ? LOAD : (cfg_acc && last) ? RUN : state_q;
        cnt_d       = (cfg_start || (cfg_acc && last)) ? '0 : cfg_acc ? cnt_q + 1'b1 : cnt_q;
        loaded_d    = loaded_q | (cfg_acc && last && !cfg_start);
        out_valid_d = in_acc | (out_valid_q & !out_ready);
        out_data_d  = in_acc ? ent[in_data] : out_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            cnt_q       <= '0;
            loaded_q    <= 1'b0;
            tbl_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loaded_q    <= loaded_d;
            tbl_q       <= tbl_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
endmodule
